ioc_bus_ctrl: RTL and testbench

Sequencer that turns a byte stream from the SPI slave front-end into transactions on the shared IOC register bus (`ioc`, `cs`, `fetch_cmd`, `load_cmd`, data) used by `sys_ctrl` and the other control modules. It decodes a one-byte opcode, drives exactly one module's chip-select, and issues a single-cycle load or fetch pulse. For reads it captures the selected module's response byte and returns it to the SPI side. It sits between the SPI byte interface and all IOC-addressed modules and is the only master of that bus.

---
 rtl/ioc_pkg.sv | 48 ++++
 rtl/ioc_bus_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ioc_bus_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ioc_pkg.sv
// ---------------------------------------------------------------------------
// ioc_pkg
// Shared definitions for the IOC register bus master (ioc_bus_ctrl) and the
// IOC-addressed slave modules.
//   - opcode field positions: RW bit, module-index field, ioc field
//   - sequencer state encoding
//   - module index constants (sys_ctrl is module 0)
//   - small opcode decode helpers
// ---------------------------------------------------------------------------
package ioc_pkg;

    // Opcode byte layout: [7] = write(1)/read(0), [6:5] = module, [4:0] = ioc
    localparam int unsigned OP_RW_BIT = 7;
    localparam int unsigned OP_IDX_HI = 6;
    localparam int unsigned OP_IDX_LO = 5;
    localparam int unsigned OP_IOC_HI = 4;
    localparam int unsigned OP_IOC_LO = 0;

    // Module indices on the IOC bus
    localparam logic [1:0] MOD_SYS_CTRL = 2'd0;
    localparam logic [1:0] MOD_IDX_1    = 2'd1;
    localparam logic [1:0] MOD_IDX_2    = 2'd2;
    localparam logic [1:0] MOD_IDX_3    = 2'd3;

    // Sequencer states; each state names the bus activity visible on the
    // registered outputs during that cycle.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FETCH = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DONE  = 3'd5
    } ioc_state_e;

    function automatic logic op_is_write(input logic [7:0] op);
        return op[OP_RW_BIT];
    endfunction

    function automatic logic [1:0] op_idx(input logic [7:0] op);
        return op[OP_IDX_HI:OP_IDX_LO];
    endfunction

    function automatic logic [4:0] op_ioc(input logic [7:0] op);
        return op[OP_IOC_HI:OP_IOC_LO];
    endfunction

endpackage

// File: rtl/ioc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// ioc_bus_ctrl
// Turns the SPI slave byte stream into single-cycle load/fetch transactions on
// the shared IOC register bus, and returns read data to the SPI side.
//
// Parameters:
//   NUM_MODULES    number of IOC slaves (1..4)
// Ports:
//   i_sys_clk      system clock
//   i_rst_b        asynchronous active-low reset
//   i_frame        SPI frame active (synchronous to i_sys_clk)
//   i_rx_valid     one-cycle strobe qualifying i_rx_byte
//   i_rx_byte      received byte (opcode, then write data)
//   o_tx_valid     one-cycle strobe qualifying o_tx_byte
//   o_tx_byte      read response byte
//   o_ioc          IOC register address to the slaves
//   o_data_out     write data to the slaves
//   o_cs           one-hot module select
//   o_fetch_cmd    read pulse
//   o_load_cmd     write pulse
//   i_rd_data      slave read buses, module k at [8k+7:8k]
//
// Build option: define IOC_BURST_EN to let a frame continue with further
// transfers at ioc+1 (wrapping 31 -> 0) instead of stopping after one.
// ---------------------------------------------------------------------------
module ioc_bus_ctrl
    import ioc_pkg::*;
#(
    parameter int NUM_MODULES = 4
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_b,
    input  logic                     i_frame,
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_byte,
    output logic                     o_tx_valid,
    output logic [7:0]               o_tx_byte,
    output logic [4:0]               o_ioc,
    output logic [7:0]               o_data_out,
    output logic [NUM_MODULES-1:0]   o_cs,
    output logic                     o_fetch_cmd,
    output logic                     o_load_cmd,
    input  logic [8*NUM_MODULES-1:0] i_rd_data
);

    ioc_state_e             state_q;
    logic [1:0]             idx_q;
    logic [4:0]             ioc_q;
    logic [7:0]             data_q;
    logic [NUM_MODULES-1:0] cs_q;
    logic                   fetch_q;
    logic                   load_q;
    logic                   tx_valid_q;
    logic [7:0]             tx_byte_q;
`ifdef IOC_BURST_EN
    logic                   rw_q;
    logic                   burst_q;   // set once the first write of a frame is done
`endif

    logic [NUM_MODULES-1:0] cs_new_s;   // select decoded from an incoming opcode
    logic [NUM_MODULES-1:0] cs_cur_s;   // select decoded from the latched opcode
    logic [7:0]             rd_slice_s; // read byte of the latched module, 0 if absent

    // Module select decode and read-data mux; indices beyond NUM_MODULES match nothing
    always_comb begin
        cs_new_s   = '0;
        cs_cur_s   = '0;
        rd_slice_s = 8'h00;
        for (int k = 0; k < NUM_MODULES; k++) begin
            cs_new_s[k] = (op_idx(i_rx_byte) == 2'(k));
            cs_cur_s[k] = (idx_q == 2'(k));
            rd_slice_s  = (idx_q == 2'(k)) ? i_rd_data[8*k +: 8] : rd_slice_s;
        end
    end

    // Transaction sequencer with registered bus outputs
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            ioc_q      <= 5'd0;
            data_q     <= 8'h00;
            cs_q       <= '0;
            fetch_q    <= 1'b0;
            load_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
`ifdef IOC_BURST_EN
            rw_q       <= 1'b0;
            burst_q    <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle unless re-armed below
            fetch_q    <= 1'b0;
            load_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_q <= '0;
                    if (i_frame && i_rx_valid) begin
                        idx_q <= op_idx(i_rx_byte);
                        ioc_q <= op_ioc(i_rx_byte);
`ifdef IOC_BURST_EN
                        rw_q    <= op_is_write(i_rx_byte);
                        burst_q <= 1'b0;
`endif
                        if (op_is_write(i_rx_byte)) begin
                            state_q <= ST_WDATA;
                        end else begin
                            // Decode from the incoming byte so the fetch lands in N+1
                            state_q <= ST_FETCH;
                            fetch_q <= 1'b1;
                            cs_q    <= cs_new_s;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (!i_frame) begin
                        state_q <= ST_IDLE;
                    end else if (i_rx_valid) begin
                        data_q  <= i_rx_byte;
                        load_q  <= 1'b1;
                        cs_q    <= cs_cur_s;
                        state_q <= ST_LOAD;
`ifdef IOC_BURST_EN
                        if (burst_q) begin
                            ioc_q <= ioc_q + 5'd1;
                        end else begin
                            ioc_q <= ioc_q;
                        end
`endif
                    end else begin
                        state_q <= ST_WDATA;
                    end
                end
                ST_LOAD: begin
                    cs_q <= '0;
                    if (!i_frame) begin
                        state_q <= ST_IDLE;
                    end else begin
`ifdef IOC_BURST_EN
                        state_q <= ST_WDATA;
                        burst_q <= 1'b1;
`else
                        state_q <= ST_DONE;
`endif
                    end
                end
                ST_FETCH: begin
                    // The fetch pulse already on the bus completes either way
                    if (!i_frame) begin
                        state_q <= ST_IDLE;
                        cs_q    <= '0;
                    end else begin
                        state_q <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    // Slave data is valid now; the response is delivered even if
                    // the frame has just ended
                    tx_byte_q  <= rd_slice_s;
                    tx_valid_q <= 1'b1;
                    cs_q       <= '0;
                    state_q    <= i_frame ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    cs_q <= '0;
                    if (!i_frame) begin
                        state_q <= ST_IDLE;
`ifdef IOC_BURST_EN
                    end else if (i_rx_valid && !rw_q) begin
                        // Read burst: any further byte fetches the next register
                        ioc_q   <= ioc_q + 5'd1;
                        fetch_q <= 1'b1;
                        cs_q    <= cs_cur_s;
                        state_q <= ST_FETCH;
`endif
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_q    <= '0;
                end
            endcase
        end
    end

    assign o_tx_valid  = tx_valid_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_ioc       = ioc_q;
    assign o_data_out  = data_q;
    assign o_cs        = cs_q;
    assign o_fetch_cmd = fetch_q;
    assign o_load_cmd  = load_q;

endmodule

// File: tb/tb_ioc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ioc_bus_ctrl
// Drives SPI-style frames into ioc_bus_ctrl (NUM_MODULES = 3 so that module
// index 3 is absent) and compares every observed bus event (load, fetch,
// tx response) with an event list predicted from the opcode rules.
// ---------------------------------------------------------------------------
module tb_ioc_bus_ctrl;

    localparam int NM = 3;
`ifdef IOC_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int EV_LOAD  = 1;
    localparam int EV_FETCH = 2;
    localparam int EV_TX    = 3;

    typedef struct {
        int            kind;
        int            cyc;
        logic [4:0]    ioc;
        logic [7:0]    data;
        logic [NM-1:0] cs;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            frame;
    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            tx_valid;
    logic [7:0]      tx_byte;
    logic [4:0]      ioc;
    logic [7:0]      data_out;
    logic [NM-1:0]   cs;
    logic            fetch_cmd;
    logic            load_cmd;
    logic [8*NM-1:0] rd_data;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errs = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    ioc_bus_ctrl #(.NUM_MODULES(NM)) dut (
        .i_sys_clk  (clk),
        .i_rst_b    (rst_b),
        .i_frame    (frame),
        .i_rx_valid (rx_valid),
        .i_rx_byte  (rx_byte),
        .o_tx_valid (tx_valid),
        .o_tx_byte  (tx_byte),
        .o_ioc      (ioc),
        .o_data_out (data_out),
        .o_cs       (cs),
        .o_fetch_cmd(fetch_cmd),
        .o_load_cmd (load_cmd),
        .i_rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record bus events in the middle of each cycle
    always @(negedge clk) begin
        ev_t e;
        if (rst_b) begin
            if (load_cmd) begin
                e = '{kind: EV_LOAD, cyc: cyc, ioc: ioc, data: data_out, cs: cs};
                obs_q.push_back(e);
            end
            if (fetch_cmd) begin
                e = '{kind: EV_FETCH, cyc: cyc, ioc: ioc, data: 8'h00, cs: cs};
                obs_q.push_back(e);
            end
            if (tx_valid) begin
                e = '{kind: EV_TX, cyc: cyc, ioc: 5'd0, data: tx_byte, cs: '0};
                obs_q.push_back(e);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kind, input int c, input logic [4:0] io,
                            input logic [7:0] d, input logic [NM-1:0] s);
        ev_t e;
        e = '{kind: kind, cyc: c, ioc: io, data: d, cs: s};
        exp_q.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_tx_byte"},  32'(tx_byte),  32'd0);
        chk({tag, "_ioc"},      32'(ioc),      32'd0);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_cs"},       32'(cs),       32'd0);
        chk({tag, "_fetch"},    32'(fetch_cmd),32'd0);
        chk({tag, "_load"},     32'(load_cmd), 32'd0);
    endtask

    // Compare the observed event list of the last frame with the prediction
    task automatic compare_frame(input string tag);
        int n;
        chk({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            chk({tag, "_cyc"},  32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
            chk({tag, "_ioc"},  32'(obs_q[i].ioc),  32'(exp_q[i].ioc));
            chk({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
            chk({tag, "_cs"},   32'(obs_q[i].cs),   32'(exp_q[i].cs));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Send one frame of n bytes and predict its bus events from the opcode rules
    task automatic send_frame(input string tag, input int n,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [8*NM-1:0] rd);
        logic [7:0]    b [4];
        bit            wr;
        int            idx;
        logic [4:0]    ioc0;
        logic [NM-1:0] ecs;
        logic [7:0]    erd;
        int            t;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        wr   = b0[7];
        idx  = int'(b0[6:5]);
        ioc0 = b0[4:0];
        ecs  = '0;
        erd  = 8'h00;
        if (idx < NM) begin
            ecs[idx] = 1'b1;
            erd      = rd[8*idx +: 8];
        end
        step();
        frame   = 1'b1;
        rd_data = rd;
        for (int i = 0; i < n; i++) begin
            step();
            rx_valid = 1'b1;
            rx_byte  = b[i];
            t        = cyc;
            if (i == 0 && !wr) begin
                push_exp(EV_FETCH, t + 1, ioc0, 8'h00, ecs);
                push_exp(EV_TX, t + 3, 5'd0, erd, '0);
            end else if (i > 0 && wr && (i == 1 || BURST)) begin
                push_exp(EV_LOAD, t + 1, ioc0 + 5'(i - 1), b[i], ecs);
            end else if (i > 0 && !wr && BURST) begin
                push_exp(EV_FETCH, t + 1, ioc0 + 5'(i), 8'h00, ecs);
                push_exp(EV_TX, t + 3, 5'd0, erd, '0);
            end
            step();
            rx_valid = 1'b0;
            rx_byte  = 8'($urandom);
            repeat ($urandom_range(1, 3)) step();
        end
        repeat (3) step();
        frame = 1'b0;
        step();
        step();
        compare_frame(tag);
    endtask

    initial begin
        rst_b    = 1'b0;
        frame    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        rd_data  = '0;
        repeat (3) step();
        check_outputs_zero("reset");
        rst_b = 1'b1;
        repeat (2) step();

        // Directed frames
        send_frame("rd_m0", 1, 8'h00, 8'h00, 8'h00, 8'h00, {8'hC3, 8'h7E, 8'h01});
        send_frame("wr_a3", 3, 8'hA3, 8'h5A, 8'h77, 8'h00, 24'($urandom));
        send_frame("rd_absent", 1, 8'h60, 8'h00, 8'h00, 8'h00, 24'($urandom));
        send_frame("wr_drop", 1, 8'h81, 8'h00, 8'h00, 8'h00, 24'($urandom));
        send_frame("wr_after_drop", 2, 8'h81, 8'h3C, 8'h00, 8'h00, 24'($urandom));
        send_frame("wr_bf", 3, 8'hBF, 8'h11, 8'h22, 8'h00, 24'($urandom));
        send_frame("rd_burst", 3, 8'h5E, 8'h00, 8'h00, 8'h00, {8'h99, 8'h42, 8'h10});

        // Reset asserted during the capture cycle of a read
        step();
        frame   = 1'b1;
        rd_data = {8'hAA, 8'h55, 8'h11};
        step();
        rx_valid = 1'b1;
        rx_byte  = 8'h22;
        step();
        rx_valid = 1'b0;
        step();
        chk("capt_cs_held", 32'(cs), 32'(3'b010));
        #2;
        rst_b = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        frame = 1'b0;
        obs_q.delete();
        exp_q.delete();
        step();
        step();
        rst_b = 1'b1;
        repeat (5) step();
        chk("rst_no_events", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        send_frame("rd_after_rst", 1, 8'h25, 8'h00, 8'h00, 8'h00, {8'h0F, 8'hE1, 8'h5C});

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            send_frame("rand", int'($urandom_range(1, 4)), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), 24'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
